ccip_mmio_responder: RTL

//  AFU-side responder for host-initiated CCI-P MMIO accesses: decodes MMIO read/write requests arriving on c0 Rx.

---
 rtl/ccip_mmio_responder.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/ccip_mmio_responder.sv
// ccip_mmio_responder
//   AFU-side responder for host MMIO accesses arriving on CCI-P c0 Rx.
//   Reads are answered on c2 Tx with a fixed two-cycle latency; writes update
//   a bank of NUM_REGS 64-bit user CSRs. The map holds the DFH/AFU_ID block,
//   the user CSRs at REG_BASE and NUM_STATUS read-only status words at
//   STATUS_BASE. All addresses are DWORD addresses.
// Ports
//   pClk, pReset_n      clock, synchronous active-low reset
//   rx_mmio_*           MMIO request (wr/rd strobes, addr, len, tid, wdata)
//   tx_mmio_rsp_*       read response (valid, echoed tid, data)
//   csr_q               user CSR contents, CSR i at [64*i+:64]
//   csr_wr_pulse        one-cycle pulse per CSR written
//   status_in           RO status words, sampled when a read is answered
module ccip_mmio_responder #(
    parameter int unsigned NUM_REGS    = 8,
    parameter int unsigned NUM_STATUS  = 4,
    parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_0000,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter logic [15:0] REG_BASE    = 16'h0020,
    parameter logic [15:0] STATUS_BASE = 16'h0040
) (
    input  logic                     pClk,
    input  logic                     pReset_n,
    input  logic                     rx_mmio_wr_valid,
    input  logic                     rx_mmio_rd_valid,
    input  logic [15:0]              rx_mmio_addr,
    input  logic [1:0]               rx_mmio_len,
    input  logic [8:0]               rx_mmio_tid,
    input  logic [63:0]              rx_mmio_wdata,
    output logic                     tx_mmio_rsp_valid,
    output logic [8:0]               tx_mmio_rsp_tid,
    output logic [63:0]              tx_mmio_rsp_data,
    output logic [NUM_REGS*64-1:0]   csr_q,
    output logic [NUM_REGS-1:0]      csr_wr_pulse,
    input  logic [NUM_STATUS*64-1:0] status_in
);

    // 64-bit word indices of the CSR and status regions
    localparam logic [14:0] REG_W  = REG_BASE[15:1];
    localparam logic [14:0] STAT_W = STATUS_BASE[15:1];

    logic [14:0]         addr_w;
    logic [NUM_REGS-1:0] wr_hit;
    logic                rd_csr_hit;
    logic [63:0]         rd_csr_word;

    logic                rd_v1;
    logic [15:0]         rd_addr1;
    logic [1:0]          rd_len1;
    logic [8:0]          rd_tid1;
    logic                rd_csr_hit1;
    logic [63:0]         rd_csr_word1;

    logic [14:0]         rd_w1;
    logic [63:0]         word2;
    logic [31:0]         half2;
    logic [63:0]         rsp_next;

    assign addr_w = rx_mmio_addr[15:1];
    assign rd_w1  = rd_addr1[15:1];

    // Request-cycle CSR decode, shared by the write path and read stage 1
    always_comb begin
        wr_hit      = '0;
        rd_csr_hit  = 1'b0;
        rd_csr_word = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (addr_w == REG_W + 15'(i)) begin
                wr_hit[i]   = rx_mmio_wr_valid;
                rd_csr_hit  = 1'b1;
                rd_csr_word = csr_q[64*i +: 64];
            end
        end
    end

    // CSR write path: 8B replaces the word, 4B replaces the half at addr[0]
    always_ff @(posedge pClk) begin
        if (!pReset_n) begin
            csr_q        <= '0;
            csr_wr_pulse <= '0;
        end else begin
            csr_wr_pulse <= wr_hit;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_hit[i]) begin
                    if (rx_mmio_len != 2'b00) begin
                        csr_q[64*i +: 64] <= rx_mmio_wdata;
                    end else if (rx_mmio_addr[0]) begin
                        csr_q[64*i+32 +: 32] <= rx_mmio_wdata[31:0];
                    end else begin
                        csr_q[64*i +: 32] <= rx_mmio_wdata[31:0];
                    end
                end
            end
        end
    end

    // Read stage 1. The CSR word is captured here, before a same-cycle write
    // lands, so a read alongside a write returns the pre-write value while a
    // read one cycle after a write still sees the new value.
    always_ff @(posedge pClk) begin
        if (!pReset_n) begin
            rd_v1        <= 1'b0;
            rd_addr1     <= '0;
            rd_len1      <= '0;
            rd_tid1      <= '0;
            rd_csr_hit1  <= 1'b0;
            rd_csr_word1 <= '0;
        end else begin
            rd_v1        <= rx_mmio_rd_valid;
            rd_addr1     <= rx_mmio_addr;
            rd_len1      <= rx_mmio_len;
            rd_tid1      <= rx_mmio_tid;
            rd_csr_hit1  <= rd_csr_hit;
            rd_csr_word1 <= rd_csr_word;
        end
    end

    // Read stage 2: fixed block, status words (sampled live) or zero
    always_comb begin
        word2 = '0;
        if (rd_csr_hit1) begin
            word2 = rd_csr_word1;
        end else begin
            case (rd_w1)
                15'd0:   word2 = DFH_VALUE;
                15'd1:   word2 = AFU_ID_L;
                15'd2:   word2 = AFU_ID_H;
                default: word2 = '0;
            endcase
            for (int unsigned i = 0; i < NUM_STATUS; i++) begin
                if (rd_w1 == STAT_W + 15'(i)) begin
                    word2 = status_in[64*i +: 64];
                end
            end
        end
        half2    = rd_addr1[0] ? word2[63:32] : word2[31:0];
        rsp_next = (rd_len1 == 2'b00) ? {half2, half2} : word2;
    end

    always_ff @(posedge pClk) begin
        if (!pReset_n) begin
            tx_mmio_rsp_valid <= 1'b0;
            tx_mmio_rsp_tid   <= '0;
            tx_mmio_rsp_data  <= '0;
        end else begin
            tx_mmio_rsp_valid <= rd_v1;
            if (rd_v1) begin
                tx_mmio_rsp_tid  <= rd_tid1;
                tx_mmio_rsp_data <= rsp_next;
            end
        end
    end

endmodule
